axis_result_tx: RTL and testbench
=================================

AXIS_RESULT_TX -- requirements
Module: axis_result_tx

Interface
REQ-001 Parameter C_M00_AXIS_TDATA_WIDTH, default 64: output beat width, fixed at 2*RES_WIDTH.
REQ-002 Parameter RES_WIDTH, default 32: width of one result word from the processing core.
REQ-003 Parameter FIFO_DEPTH, default 8 (power of 2): output beat buffer depth.
REQ-004 Port aclk, input, 1: the block's only clock; all logic is rising-edge on aclk.
REQ-005 Port aresetn, input, 1: asynchronous, active-low reset.
REQ-006 Port res_valid, input, 1: result word valid from core.
REQ-007 Port res_data, input, RES_WIDTH: result word.
REQ-008 Port res_last, input, 1: final result of the job; forces flush and tlast.
REQ-009 Port res_ready, output, 1: block accepts the result word.
REQ-010 Port frame_beats, input, 16: beats per frame; sampled at frame start; 0 is treated as 1.
REQ-011 Ports m00_axis_tvalid/m00_axis_tdata/m00_axis_tlast, output, 1/64/1: AXI-Stream master toward DMA S2MM.
REQ-012 Port m00_axis_tready, input, 1: downstream backpressure.
REQ-013 Port frame_done, output, 1: one-cycle pulse on each tlast handshake.

Function
REQ-014 A result is accepted on any rising edge with res_valid && res_ready.
REQ-015 res_ready SHALL equal !fifo_full; it SHALL NOT depend on res_valid.
REQ-016 Packer states: EMPTY (no half held), HALF (low word held).
- EMPTY + accept, !res_last -> HALF; word latched as low half.
- EMPTY + accept, res_last -> push {res_data in low half, zeros in high half}, tlast=1; stay EMPTY.
- HALF + accept -> push {res_data in high half, held low half}; -> EMPTY.
REQ-017 A pushed beat carries tlast=1 if res_last was set on the accepted word or if the frame beat counter equals the sampled frame length minus 1; either condition then resets the counter to 0.
REQ-018 Frame length is sampled from frame_beats on the first push after reset or after a tlast push.
REQ-019 The FIFO is first-word-fall-through: a beat pushed into an empty FIFO SHALL appear on m00_axis_tvalid the cycle after the push edge (latency 1).
REQ-020 m00_axis_tdata and m00_axis_tlast SHALL remain stable while m00_axis_tvalid && !m00_axis_tready; tvalid SHALL NOT drop without a handshake.
REQ-021 A simultaneous push and pop on a full FIFO cannot occur (res_ready=0); a simultaneous push and pop at any other occupancy SHALL keep occupancy unchanged.
REQ-022 frame_done SHALL pulse on the cycle after a handshake with tlast=1.
REQ-023 Word order is fixed: the earlier result occupies bits [31:0] and the later result occupies [63:32].

Reset
REQ-024 While aresetn=0: state=EMPTY, FIFO empty, beat counter=0, m00_axis_tvalid=0, m00_axis_tlast=0, m00_axis_tdata=0, frame_done=0, res_ready=0.
REQ-025 res_ready SHALL rise on the first edge after aresetn deasserts.
REQ-026 A reset asserted mid-frame or mid-pair SHALL discard the held half and all buffered beats; no partial beat is emitted afterward.

Structure
REQ-027 Shared package cordic_axis_pkg holds RES_WIDTH, AXIS width, the packer state enum, and the FIFO entry type {tlast, tdata}.
REQ-028 Sub-module axis_tx_fifo is a synchronous FWFT FIFO with full/empty flags and an aresetn input; the packer and frame counter live in axis_result_tx.

Verification
REQ-029 frame_beats=4, 8 results 0x1..0x8, tready=1 -> 4 beats 0x00000002_00000001 .. 0x00000008_00000007; tlast only on beat 4; one frame_done pulse.
REQ-030 3 results 0xA,0xB,0xC, res_last on 0xC, frame_beats=16 -> beats 0x0000000B_0000000A (tlast=0), 0x00000000_0000000C (tlast=1).
REQ-031 tready=0, 20 results streamed -> res_ready falls after 8 beats are buffered; hold tdata constant; then tready=1 -> all 10 beats delivered in order with none lost.
REQ-032 Random tready toggling (50%), 64 results, frame_beats=8 -> output matches the reference packing model; 4 tlasts; tdata is stable under stall.
REQ-033 aresetn pulsed with HALF state and 3 beats buffered -> tvalid=0 the next cycle; the following 2 results form a fresh beat with no stale data.
REQ-034 frame_beats=0 -> every beat has tlast=1.

Source files
------------

// File: rtl/cordic_axis_pkg.sv
// -----------------------------------------------------------------------------
// cordic_axis_pkg
// Shared definitions for the result-to-AXI-Stream transmit path:
//   AXIS_RES_WIDTH   - width of one result word from the processing core
//   AXIS_TDATA_WIDTH - width of one output beat (two result words)
//   pack_state_e     - packer state (EMPTY: nothing held, HALF: low word held)
//   tx_entry_t       - one buffered output beat {tlast, tdata}
// -----------------------------------------------------------------------------
package cordic_axis_pkg;

   localparam int AXIS_RES_WIDTH   = 32;
   localparam int AXIS_TDATA_WIDTH = 2 * AXIS_RES_WIDTH;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HALF  = 1'b1
   } pack_state_e;

   typedef struct packed {
      logic                        tlast;
      logic [AXIS_TDATA_WIDTH-1:0] tdata;
   } tx_entry_t;

endpackage

// File: rtl/axis_tx_fifo.sv
// -----------------------------------------------------------------------------
// axis_tx_fifo
// Synchronous first-word-fall-through FIFO. The head entry is presented
// combinationally on pop_data_o whenever the FIFO is not empty; a pop
// consumes it on the next rising edge. Output data is forced to zero while
// empty so nothing stale is ever visible downstream.
// Ports:
//   aclk, aresetn  - clock, asynchronous active-low reset
//   push_i         - write push_data_i (ignored when full)
//   push_data_i    - entry to write
//   pop_i          - consume head entry (ignored when empty)
//   pop_data_o     - head entry (zero when empty)
//   full_o/empty_o - occupancy flags
// -----------------------------------------------------------------------------
module axis_tx_fifo #(
   parameter int WIDTH = 65,
   parameter int DEPTH = 8
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is pure datapath; validity is tracked by the pointers above.
   always_ff @(posedge aclk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/axis_result_tx.sv
// -----------------------------------------------------------------------------
// axis_result_tx
// Packs pairs of result words from the processing core into AXI-Stream
// beats for a DMA S2MM channel. The earlier word of a pair lands in the low
// half of the beat. A word flagged res_last is flushed immediately (alone in
// the low half if no partner is held) with tlast set. tlast is also raised
// every frame_beats beats; the frame length is sampled at the first beat of
// each frame and a length of 0 behaves as 1.
// Ports:
//   aclk, aresetn            - clock, asynchronous active-low reset
//   res_valid/res_data/
//   res_last/res_ready       - result word handshake from the core
//   frame_beats              - beats per frame (sampled at frame start)
//   m00_axis_tvalid/tdata/
//   tlast/tready             - AXI-Stream master toward the DMA
//   frame_done               - one-cycle pulse after each tlast handshake
// -----------------------------------------------------------------------------
module axis_result_tx
   import cordic_axis_pkg::*;
#(
   parameter int C_M00_AXIS_TDATA_WIDTH = AXIS_TDATA_WIDTH,
   parameter int RES_WIDTH              = AXIS_RES_WIDTH,
   parameter int FIFO_DEPTH             = 8
) (
   input  logic                              aclk,
   input  logic                              aresetn,
   input  logic                              res_valid,
   input  logic [RES_WIDTH-1:0]              res_data,
   input  logic                              res_last,
   output logic                              res_ready,
   input  logic [15:0]                       frame_beats,
   output logic                              m00_axis_tvalid,
   output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
   output logic                              m00_axis_tlast,
   input  logic                              m00_axis_tready,
   output logic                              frame_done
);

   localparam int ENTRY_W = C_M00_AXIS_TDATA_WIDTH + 1;

   pack_state_e                       state_q, state_d;
   logic [RES_WIDTH-1:0]              low_q, low_d;
   logic                              rdy_en_q;
   logic [15:0]                       beat_cnt_q, beat_cnt_d;
   logic [15:0]                       frame_len_q, frame_len_d;
   logic                              frame_open_q, frame_open_d;
   logic                              frame_done_q, frame_done_d;

   logic                              accept;
   logic                              push;
   logic                              push_last_req;
   logic                              push_tlast;
   logic [C_M00_AXIS_TDATA_WIDTH-1:0] push_data;
   logic [15:0]                       len_eff;
   logic                              fifo_full;
   logic                              fifo_empty;
   logic [ENTRY_W-1:0]                pop_entry;

   // rdy_en_q holds res_ready low during reset and releases it on the first
   // edge afterwards; ready never looks at res_valid.
   assign res_ready = rdy_en_q && !fifo_full;
   assign accept    = res_valid && res_ready;

   // Packer: pairs words, flushes a lone word on res_last.
   always_comb begin
      state_d       = state_q;
      low_d         = low_q;
      push          = 1'b0;
      push_last_req = 1'b0;
      push_data     = '0;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               if (res_last) begin
                  push          = 1'b1;
                  push_last_req = 1'b1;
                  push_data     = {{RES_WIDTH{1'b0}}, res_data};
               end else begin
                  state_d = ST_HALF;
                  low_d   = res_data;
               end
            end
         end
         ST_HALF: begin
            if (accept) begin
               push          = 1'b1;
               push_last_req = res_last;
               push_data     = {res_data, low_q};
               state_d       = ST_EMPTY;
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase
   end

   // Frame counter: the length is captured on the first beat of a frame, so
   // frame_beats may change freely while a frame is in progress.
   always_comb begin
      beat_cnt_d   = beat_cnt_q;
      frame_len_d  = frame_len_q;
      frame_open_d = frame_open_q;
      frame_done_d = m00_axis_tvalid && m00_axis_tready && m00_axis_tlast;

      if (frame_open_q) begin
         len_eff = frame_len_q;
      end else if (frame_beats == 16'd0) begin
         len_eff = 16'd1;
      end else begin
         len_eff = frame_beats;
      end

      push_tlast = push_last_req || (beat_cnt_q == (len_eff - 16'd1));

      if (push) begin
         if (push_tlast) begin
            beat_cnt_d   = 16'd0;
            frame_open_d = 1'b0;
         end else begin
            beat_cnt_d   = beat_cnt_q + 16'd1;
            frame_open_d = 1'b1;
            frame_len_d  = len_eff;
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q      <= ST_EMPTY;
         rdy_en_q     <= 1'b0;
         beat_cnt_q   <= 16'd0;
         frame_len_q  <= 16'd1;
         frame_open_q <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         rdy_en_q     <= 1'b1;
         beat_cnt_q   <= beat_cnt_d;
         frame_len_q  <= frame_len_d;
         frame_open_q <= frame_open_d;
         frame_done_q <= frame_done_d;
      end
   end

   // The held low word is only meaningful in ST_HALF, which reset clears.
   always_ff @(posedge aclk) begin
      low_q <= low_d;
   end

   axis_tx_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .push_i      (push),
      .push_data_i ({push_tlast, push_data}),
      .pop_i       (m00_axis_tready),
      .pop_data_o  (pop_entry),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   assign m00_axis_tvalid = !fifo_empty;
   assign m00_axis_tlast  = pop_entry[ENTRY_W-1];
   assign m00_axis_tdata  = pop_entry[C_M00_AXIS_TDATA_WIDTH-1:0];
   assign frame_done      = frame_done_q;

endmodule

// File: tb/tb_axis_result_tx.sv
`timescale 1ns/1ps
module tb_axis_result_tx;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        res_valid = 1'b0;
   logic [31:0] res_data = '0;
   logic        res_last = 1'b0;
   logic        res_ready;
   logic [15:0] frame_beats = 16'd4;
   logic        m00_axis_tvalid;
   logic [63:0] m00_axis_tdata;
   logic        m00_axis_tlast;
   logic        m00_axis_tready = 1'b0;
   logic        frame_done;

   axis_result_tx dut (
      .aclk            (aclk),
      .aresetn         (aresetn),
      .res_valid       (res_valid),
      .res_data        (res_data),
      .res_last        (res_last),
      .res_ready       (res_ready),
      .frame_beats     (frame_beats),
      .m00_axis_tvalid (m00_axis_tvalid),
      .m00_axis_tdata  (m00_axis_tdata),
      .m00_axis_tlast  (m00_axis_tlast),
      .m00_axis_tready (m00_axis_tready),
      .frame_done      (frame_done)
   );

   always #5 aclk = ~aclk;

   typedef struct packed {
      logic        last;
      logic [63:0] data;
   } beat_t;

   typedef struct {
      logic [31:0] d;
      logic        l;
      bit          push;
      logic [63:0] ed;
      logic        el;
   } vec_t;

   typedef struct {
      int          first;
      int          last;
      logic [15:0] fb;
      int          n_fd;
   } sc_t;

   int    n_cmp = 0;
   int    n_bad = 0;
   int    fd_cnt = 0;
   int    rx_cnt = 0;
   beat_t exp_q[$];

   bit    rand_en = 1'b0;
   logic  tready_man = 1'b0;

   bit    hold_v = 1'b0;
   logic [63:0] hold_d = '0;
   logic  hold_l = 1'b0;
   logic  fd_exp = 1'b0;

   // reference packing model
   bit          m_half = 1'b0;
   logic [31:0] m_low = '0;
   logic [15:0] m_cnt = '0;
   logic [15:0] m_len = '0;
   bit          m_open = 1'b0;

   vec_t tv[15];
   sc_t  sc[3];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input logic [63:0] d, input logic l);
      beat_t b;
      b.data = d;
      b.last = l;
      exp_q.push_back(b);
   endtask

   task automatic model_accept(input logic [31:0] d, input logic l);
      logic [63:0] bd;
      logic        bl;
      if (!m_half && !l) begin
         m_half = 1'b1;
         m_low  = d;
      end else begin
         bd = m_half ? {d, m_low} : {32'h0, d};
         m_half = 1'b0;
         if (!m_open) begin
            m_len  = (frame_beats == 16'd0) ? 16'd1 : frame_beats;
            m_open = 1'b1;
         end
         bl = l || (m_cnt == m_len - 16'd1);
         if (bl) begin
            m_cnt  = 16'd0;
            m_open = 1'b0;
         end else begin
            m_cnt = m_cnt + 16'd1;
         end
         push_exp(bd, bl);
      end
   endtask

   task automatic send(input logic [31:0] d, input logic l, input bit use_model);
      bit ok;
      ok = 1'b0;
      res_valid = 1'b1;
      res_data  = d;
      res_last  = l;
      for (int i = 0; i < 500 && !ok; i++) begin
         @(negedge aclk);
         ok = res_ready;
         @(posedge aclk);
         #1;
      end
      res_valid = 1'b0;
      res_last  = 1'b0;
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: word %h never accepted, required acceptance", d);
      end else if (use_model) begin
         model_accept(d, l);
      end
   endtask

   task automatic drain(input int budget);
      int i;
      i = 0;
      while (exp_q.size() != 0 && i < budget) begin
         @(negedge aclk);
         i++;
      end
      check("drain_empty", 64'(exp_q.size()), 64'd0);
      repeat (3) @(negedge aclk);
   endtask

   task automatic tb_reset();
      #1;
      aresetn    = 1'b0;
      res_valid  = 1'b0;
      res_last   = 1'b0;
      res_data   = '0;
      rand_en    = 1'b0;
      tready_man = 1'b0;
      @(negedge aclk);
      #1;
      check("rst_tvalid", 64'(m00_axis_tvalid), 64'd0);
      check("rst_tlast", 64'(m00_axis_tlast), 64'd0);
      check("rst_tdata", m00_axis_tdata, 64'd0);
      check("rst_frame_done", 64'(frame_done), 64'd0);
      check("rst_ready", 64'(res_ready), 64'd0);
      @(negedge aclk);
      exp_q.delete();
      m_half = 1'b0;
      m_cnt  = 16'd0;
      m_open = 1'b0;
      fd_cnt = 0;
      rx_cnt = 0;
      #1;
      aresetn = 1'b1;
      #1;
      check("ready_before_edge", 64'(res_ready), 64'd0);
      @(posedge aclk);
      #1;
      check("ready_rise", 64'(res_ready), 64'd1);
   endtask

   task automatic tready_gen();
      forever begin
         @(posedge aclk);
         #1;
         m00_axis_tready = rand_en ? 1'($urandom_range(0, 1)) : tready_man;
      end
   endtask

   task automatic monitor();
      beat_t e;
      forever begin
         @(negedge aclk);
         if (!aresetn) begin
            hold_v = 1'b0;
            fd_exp = 1'b0;
         end else begin
            check("frame_done", 64'(frame_done), 64'(fd_exp));
            if (frame_done) fd_cnt++;
            if (hold_v) begin
               check("stall_tvalid", 64'(m00_axis_tvalid), 64'd1);
               check("stall_tdata", m00_axis_tdata, hold_d);
               check("stall_tlast", 64'(m00_axis_tlast), 64'(hold_l));
            end
            fd_exp = m00_axis_tvalid && m00_axis_tready && m00_axis_tlast;
            if (m00_axis_tvalid && m00_axis_tready) begin
               rx_cnt++;
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_beat: got %h, required no beat", m00_axis_tdata);
               end else begin
                  e = exp_q.pop_front();
                  check("beat_tdata", m00_axis_tdata, e.data);
                  check("beat_tlast", 64'(m00_axis_tlast), 64'(e.last));
               end
               hold_v = 1'b0;
            end else if (m00_axis_tvalid) begin
               hold_v = 1'b1;
               hold_d = m00_axis_tdata;
               hold_l = m00_axis_tlast;
            end else begin
               hold_v = 1'b0;
            end
         end
      end
   endtask

   initial begin
      // vectors: 8 words frame_beats=4; short job with res_last; frame_beats=0
      for (int i = 0; i < 8; i++) begin
         tv[i] = '{32'(i + 1), 1'b0, (i % 2 == 1), {32'(i + 1), 32'(i)}, (i == 7)};
      end
      tv[8]  = '{32'h0000_000A, 1'b0, 1'b0, 64'h0, 1'b0};
      tv[9]  = '{32'h0000_000B, 1'b0, 1'b1, 64'h0000000B_0000000A, 1'b0};
      tv[10] = '{32'h0000_000C, 1'b1, 1'b1, 64'h00000000_0000000C, 1'b1};
      tv[11] = '{32'h0000_0021, 1'b0, 1'b0, 64'h0, 1'b0};
      tv[12] = '{32'h0000_0022, 1'b0, 1'b1, 64'h00000022_00000021, 1'b1};
      tv[13] = '{32'h0000_0023, 1'b0, 1'b0, 64'h0, 1'b0};
      tv[14] = '{32'h0000_0024, 1'b0, 1'b1, 64'h00000024_00000023, 1'b1};
      sc[0]  = '{0, 7, 16'd4, 1};
      sc[1]  = '{8, 10, 16'd16, 1};
      sc[2]  = '{11, 14, 16'd0, 2};

      fork
         monitor();
         tready_gen();
         begin
            #500000;
            $display("FAIL watchdog: simulation time limit reached");
            $fatal(1, "watchdog");
         end
      join_none

      // table-driven scenarios
      for (int s = 0; s < 3; s++) begin
         tb_reset();
         frame_beats = sc[s].fb;
         tready_man  = 1'b1;
         for (int i = sc[s].first; i <= sc[s].last; i++) begin
            if (tv[i].push) push_exp(tv[i].ed, tv[i].el);
            send(tv[i].d, tv[i].l, 1'b0);
         end
         drain(200);
         check("table_fd_count", 64'(fd_cnt), 64'(sc[s].n_fd));
      end

      // backpressure: fill the buffer, then release
      tb_reset();
      frame_beats = 16'd16;
      for (int i = 0; i < 16; i++) send(32'h100 + 32'(i), 1'b0, 1'b1);
      @(negedge aclk);
      check("ready_full", 64'(res_ready), 64'd0);
      check("full_tvalid", 64'(m00_axis_tvalid), 64'd1);
      check("full_head", m00_axis_tdata, 64'h00000101_00000100);
      tready_man = 1'b1;
      for (int i = 16; i < 20; i++) send(32'h100 + 32'(i), 1'b0, 1'b1);
      drain(300);
      check("bp_beat_count", 64'(rx_cnt), 64'd10);

      // random tready, frame_beats=8
      tb_reset();
      frame_beats = 16'd8;
      rand_en = 1'b1;
      for (int i = 0; i < 64; i++) send(32'h1000 + 32'(i), 1'b0, 1'b1);
      drain(2000);
      check("rand_fd_count", 64'(fd_cnt), 64'd4);
      check("rand_beat_count", 64'(rx_cnt), 64'd32);

      // reset mid-pair with three beats buffered
      tb_reset();
      frame_beats = 16'd16;
      for (int i = 0; i < 7; i++) send(32'h51 + 32'(i), 1'b0, 1'b1);
      repeat (2) @(negedge aclk);
      check("pre_rst_tvalid", 64'(m00_axis_tvalid), 64'd1);
      check("pre_rst_head", m00_axis_tdata, 64'h00000052_00000051);
      tb_reset();
      tready_man = 1'b1;
      send(32'h61, 1'b0, 1'b1);
      send(32'h62, 1'b0, 1'b1);
      drain(200);
      repeat (5) @(negedge aclk);
      check("post_rst_beat_count", 64'(rx_cnt), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
